// File: rtl/chip8_mem_pkg.sv
// CHIP-8 memory arbiter shared constants.
// Requester indices and arbiter FSM encoding.
package chip8_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  localparam int REQ_CPU  = 0;
  localparam int REQ_DISP = 1;
  localparam int REQ_LOAD = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches from ptr_i+1 upward, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [IW-1:0]      gnt_o,
  output logic               valid_o
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt_o   = '0;
    valid_o = 1'b0;
    // farthest first, so the nearest set bit wins
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[idx]) begin
        gnt_o   = IW'(idx);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// CHIP-8 4 KiB memory arbiter: round-robin,
// one transaction at a time, read watchdog.
module mem_arbiter
  import chip8_mem_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       mem_read,
  output logic [ADDR_WIDTH-1:0]      mem_read_addr,
  input  logic [DATA_WIDTH-1:0]      mem_read_data,
  input  logic                       mem_read_ack,
  output logic                       mem_write,
  output logic [ADDR_WIDTH-1:0]      mem_write_addr,
  output logic [DATA_WIDTH-1:0]      mem_write_data,
  output logic                       busy,
  output logic                       err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         gnt_q, gnt_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic [IW-1:0]         pick_gnt;
  logic                  pick_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ack_d   = '0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          ptr_d   = pick_gnt;
          we_d    = req_we[pick_gnt];
          addr_d  = req_addr[int'(pick_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[int'(pick_gnt)*DATA_WIDTH +: DATA_WIDTH];
          rd_d    = ~req_we[pick_gnt];
          wr_d    = req_we[pick_gnt];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        if (we_q) begin
          ack_d[gnt_q] = 1'b1;
          state_d      = ST_ACK;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_read_ack) begin
          rdata_d      = mem_read_data;
          ack_d[gnt_q] = 1'b1;
          state_d      = ST_ACK;
        end else if (cnt_q == CW'(RD_TIMEOUT)) begin
          rdata_d      = '0;
          err_d        = 1'b1;
          ack_d[gnt_q] = 1'b1;
          state_d      = ST_ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ACK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign ack            = ack_q;
  assign rdata          = rdata_q;
  assign mem_read       = rd_q;
  assign mem_read_addr  = addr_q;
  assign mem_write      = wr_q;
  assign mem_write_addr = addr_q;
  assign mem_write_data = wdata_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a
// 1-cycle-ack memory model.
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  req_we;
  logic [AW-1:0] a0, a1, a2;
  logic [DW-1:0] w0, w1, w2;
  logic [N-1:0]  ack;
  logic [DW-1:0] rdata;
  logic          mem_read;
  logic [AW-1:0] mem_read_addr;
  logic [DW-1:0] mem_read_data = '0;
  logic          mem_read_ack = 1'b0;
  logic          mem_write;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic          busy;
  logic          err;

  logic          no_ack = 1'b0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] mem [4096];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_we         (req_we),
    .req_addr       ({a2, a1, a0}),
    .req_wdata      ({w2, w1, w0}),
    .ack            (ack),
    .rdata          (rdata),
    .mem_read       (mem_read),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .mem_read_ack   (mem_read_ack),
    .mem_write      (mem_write),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .busy           (busy),
    .err            (err)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_write) mem[mem_write_addr] <= mem_write_data;
    mem_read_ack  <= mem_read && !no_ack;
    mem_read_data <= mem[mem_read_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (ack != '0) break;
    end
  endtask

  int n;
  logic [N-1:0] exp_g [6];

  initial begin
    rst_n = 1'b0;
    req = '0; req_we = '0;
    a0 = '0; a1 = '0; a2 = '0;
    w0 = '0; w1 = '0; w2 = '0;
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    preload(12'h1B0, 8'hF0);
    preload(12'h300, 8'h10);
    preload(12'h301, 8'h11);
    preload(12'h302, 8'h12);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 0);
    chk("rst_addr", 32'(mem_read_addr), 0);
    rst_n = 1'b1;
    tick();

    // single read
    req = 3'b001; a0 = 12'h1B0;
    tick();
    chk("rd_strobe", 32'(mem_read), 1);
    chk("rd_addr", 32'(mem_read_addr), 32'h1B0);
    chk("rd_busy", 32'(busy), 1);
    tick();
    chk("rd_strobe_low", 32'(mem_read), 0);
    chk("rd_noack_early", 32'(ack), 0);
    tick();
    chk("rd_ack", 32'(ack), 32'b001);
    chk("rd_data", 32'(rdata), 32'hF0);
    req = '0;
    tick();
    chk("rd_ack_pulse", 32'(ack), 0);
    chk("rd_data_held", 32'(rdata), 32'hF0);
    chk("rd_idle", 32'(busy), 0);

    // write then read back
    req = 3'b100; req_we = 3'b100; a2 = 12'h200; w2 = 8'hA5;
    tick();
    chk("wr_strobe", {30'd0, mem_write, mem_read}, 32'b10);
    chk("wr_addr", 32'(mem_write_addr), 32'h200);
    chk("wr_data", 32'(mem_write_data), 32'hA5);
    tick();
    chk("wr_ack", 32'(ack), 32'b100);
    req = '0; req_we = '0;
    tick();
    req = 3'b001; a0 = 12'h200;
    wait_ack(n);
    chk("rb_lat", n, 3);
    chk("rb_ack", 32'(ack), 32'b001);
    chk("rb_data", 32'(rdata), 32'hA5);
    req = '0;
    tick();

    // contention from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a0 = 12'h300; a1 = 12'h301; a2 = 12'h302;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_ack(n);
      chk("rr_lat", n, (k == 0) ? 3 : 4);
      chk("rr_grant", 32'(ack), 32'(exp_g[k]));
      chk("rr_data", 32'(rdata), 32'h10 + ((k % 3)));
    end
    req = '0;
    tick();

    // read timeout
    no_ack = 1'b1;
    req = 3'b001; a0 = 12'h123;
    wait_ack(n);
    chk("to_lat", n, 3 + TO);
    chk("to_ack", 32'(ack), 32'b001);
    chk("to_rdata", 32'(rdata), 0);
    chk("to_err", 32'(err), 1);
    req = '0;
    no_ack = 1'b0;
    tick();
    req = 3'b001; a0 = 12'h1B0;
    wait_ack(n);
    chk("to_after_data", 32'(rdata), 32'hF0);
    chk("to_err_sticky", 32'(err), 1);
    req = '0;
    tick();

    // reset during WAIT
    no_ack = 1'b1;
    req = 3'b010; a1 = 12'h301;
    tick();
    tick();
    tick();
    chk("mr_in_wait", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_err", 32'(err), 0);
    chk("mr_rdata", 32'(rdata), 0);
    chk("mr_ack", 32'(ack), 0);
    req = '0;
    no_ack = 1'b0;
    tick();
    chk("mr_ack_hold", 32'(ack), 0);
    rst_n = 1'b1;
    tick();
    chk("mr_no_ack", 32'(ack), 0);
    a0 = 12'h300; a1 = 12'h301; a2 = 12'h302;
    req = 3'b111;
    wait_ack(n);
    chk("mr_first", 32'(ack), 32'b001);
    chk("mr_lat", n, 3);

    // display drops req during ISSUE
    tick();
    tick();
    chk("ed_issue", 32'(mem_read_addr), 32'h301);
    req = 3'b101;
    tick();
    tick();
    chk("ed_ack", 32'(ack), 32'b010);
    chk("ed_data", 32'(rdata), 32'h11);
    wait_ack(n);
    chk("ed_next", 32'(ack), 32'b100);
    chk("ed_next_lat", n, 4);
    wait_ack(n);
    chk("ed_wrap", 32'(ack), 32'b001);
    req = '0;
    tick();
    chk("ed_quiet", 32'(ack), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
